// File: rtl/cpu_wb_pkg.sv
// Shared types and defaults for the CPU register-file writeback path.
package cpu_wb_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 4;
  localparam int DEF_DW    = 32;

  localparam logic [3:0] REG_ZERO = 4'h0;

  typedef struct packed {
    logic [DEF_AW-1:0] dst;
    logic [DEF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/cpu_wb_fifo.sv
// Load-return buffer: synchronous FIFO with a destination-register match
// query across all occupied entries.
module cpu_wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          push_dst,
  input  logic [DW-1:0]          push_data,
  input  logic [AW-1:0]          query,
  output logic [AW-1:0]          head_dst,
  output logic [DW-1:0]          head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   dst_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } req_t;

  req_t             mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Caller guarantees push only when not full and pop only when not empty,
  // so push and pop never address the same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{dst: push_dst, data: push_data};
  end

  always_comb begin
    dst_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].dst == query)) dst_hit = 1'b1;
    end
  end

  assign head_dst  = mem[rd_ptr].dst;
  assign head_data = mem[rd_ptr].data;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/cpu_wb_arb.sv
// Writeback arbiter: merges in-order ALU results with buffered load returns
// onto the single register-file write port, filtering R0 and keeping WAW order.
module cpu_wb_arb
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_vld,
  input  logic [AW-1:0]          alu_dst,
  input  logic [DW-1:0]          alu_data,
  output logic                   alu_stall,
  input  logic                   mem_vld,
  input  logic [AW-1:0]          mem_dst,
  input  logic [DW-1:0]          mem_data,
  output logic                   mem_rdy,
  output logic                   wrt_en,
  output logic [AW-1:0]          wrt_sel,
  output logic [DW-1:0]          wrt_data,
  output logic                   r0_drop,
  input  logic                   clr_r0_drop,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  logic          full;
  logic          empty;
  logic          dst_hit;
  logic          mem_acc;
  logic          push;
  logic          pop;
  logic          alu_r0;
  logic [AW-1:0] head_dst;
  logic [DW-1:0] head_data;
  logic          sel_en_p0;
  logic [AW-1:0] sel_dst_p0;
  logic [DW-1:0] sel_data_p0;

  cpu_wb_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_dst  (mem_dst),
    .push_data (mem_data),
    .query     (alu_dst),
    .head_dst  (head_dst),
    .head_data (head_data),
    .count     (fifo_cnt),
    .full      (full),
    .empty     (empty),
    .dst_hit   (dst_hit)
  );

  assign mem_rdy = !full;
  assign mem_acc = mem_vld && mem_rdy;
  assign push    = mem_acc && (mem_dst != AW'(REG_ZERO));
  assign alu_r0  = alu_vld && (alu_dst == AW'(REG_ZERO));

  // Stage p0: choose the write source. A pending load to the ALU's
  // destination, or a full buffer, forces the buffer to drain first.
  always_comb begin
    pop         = 1'b0;
    alu_stall   = 1'b0;
    sel_en_p0   = 1'b0;
    sel_dst_p0  = head_dst;
    sel_data_p0 = head_data;
    if (alu_r0) begin
      pop = !empty;
    end else if (alu_vld && !dst_hit && !full) begin
      sel_en_p0   = 1'b1;
      sel_dst_p0  = alu_dst;
      sel_data_p0 = alu_data;
    end else if (alu_vld) begin
      pop       = 1'b1;
      alu_stall = 1'b1;
    end else begin
      pop = !empty;
    end
    if (pop) sel_en_p0 = 1'b1;
  end

  // Stage p1: registered write port; index/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_en   <= 1'b0;
      wrt_sel  <= '0;
      wrt_data <= '0;
      r0_drop  <= 1'b0;
    end else begin
      wrt_en <= sel_en_p0;
      if (sel_en_p0) begin
        wrt_sel  <= sel_dst_p0;
        wrt_data <= sel_data_p0;
      end
      if (alu_r0 || (mem_acc && !push)) r0_drop <= 1'b1;
      else if (clr_r0_drop)             r0_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_wb_arb.sv
// Bench for cpu_wb_arb: directed vector table, reset sequences and a
// randomized run checked against a queue-based reference model.
module tb_cpu_wb_arb;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_vld = 1'b0;
  logic [AW-1:0] alu_dst = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_stall;
  logic          mem_vld = 1'b0;
  logic [AW-1:0] mem_dst = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_rdy;
  logic          wrt_en;
  logic [AW-1:0] wrt_sel;
  logic [DW-1:0] wrt_data;
  logic          r0_drop;
  logic          clr_r0_drop = 1'b0;
  logic [2:0]    fifo_cnt;

  cpu_wb_arb #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_vld     (alu_vld),
    .alu_dst     (alu_dst),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .mem_vld     (mem_vld),
    .mem_dst     (mem_dst),
    .mem_data    (mem_data),
    .mem_rdy     (mem_rdy),
    .wrt_en      (wrt_en),
    .wrt_sel     (wrt_sel),
    .wrt_data    (wrt_data),
    .r0_drop     (r0_drop),
    .clr_r0_drop (clr_r0_drop),
    .fifo_cnt    (fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          av;
    logic [3:0]  ad;
    logic [31:0] adat;
    bit          mv;
    logic [3:0]  md;
    logic [31:0] mdat;
    bit          clr;
    bit          stl;
    bit          rdy;
    int          cnt;
    bit          en;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          r0;
  } vec_t;

  typedef struct {
    logic [3:0]  dst;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_sel = '0;
  logic [31:0] m_dat = '0;
  bit          m_r0 = 1'b0;
  bit          m_stl = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(bit av, int ad, int adat, bit mv, int md, int mdat, bit clr,
                              bit stl, bit rdy, int cnt, bit en, int sel, int dat, bit r0);
    vec_t v;
    v.av = av;   v.ad = ad[3:0]; v.adat = adat;
    v.mv = mv;   v.md = md[3:0]; v.mdat = mdat;
    v.clr = clr; v.stl = stl;    v.rdy = rdy;  v.cnt = cnt;
    v.en = en;   v.sel = sel[3:0]; v.dat = dat; v.r0 = r0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle; the model applies the arbitration rules to a plain queue.
  task automatic apply(input vec_t v, input bit use_tbl);
    bit          hit, pop, en, rdy;
    int          cnt;
    logic [3:0]  sel;
    logic [31:0] dat;
    alu_vld = v.av; alu_dst = v.ad; alu_data = v.adat;
    mem_vld = v.mv; mem_dst = v.md; mem_data = v.mdat;
    clr_r0_drop = v.clr;
    #1;
    cnt = mq.size();
    rdy = (cnt < DEPTH);
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].dst == v.ad) hit = 1'b1;
    en = 1'b0; pop = 1'b0; m_stl = 1'b0; sel = m_sel; dat = m_dat;
    if (v.av && v.ad == 4'd0) pop = (cnt > 0);
    else if (v.av && !hit && cnt < DEPTH) begin en = 1'b1; sel = v.ad; dat = v.adat; end
    else if (v.av) begin pop = 1'b1; m_stl = 1'b1; end
    else pop = (cnt > 0);
    if (use_tbl) begin
      chk("alu_stall", alu_stall, v.stl);
      chk("mem_rdy", mem_rdy, v.rdy);
      chk("fifo_cnt", fifo_cnt, v.cnt);
    end else begin
      chk("alu_stall", alu_stall, m_stl);
      chk("mem_rdy", mem_rdy, rdy);
      chk("fifo_cnt", fifo_cnt, cnt);
    end
    if (pop) begin
      en = 1'b1; sel = mq[0].dst; dat = mq[0].data;
      void'(mq.pop_front());
    end
    if (v.mv && rdy && v.md != 4'd0) mq.push_back('{dst: v.md, data: v.mdat});
    if ((v.av && v.ad == 4'd0) || (v.mv && rdy && v.md == 4'd0)) m_r0 = 1'b1;
    else if (v.clr) m_r0 = 1'b0;
    if (en) begin m_sel = sel; m_dat = dat; end
    @(posedge clk);
    #1;
    if (use_tbl) begin
      chk("wrt_en", wrt_en, v.en);
      if (v.en) begin
        chk("wrt_sel", wrt_sel, v.sel);
        chk("wrt_data", wrt_data, v.dat);
      end
      chk("r0_drop", r0_drop, v.r0);
    end else begin
      chk("wrt_en", wrt_en, en);
      chk("wrt_sel", wrt_sel, m_sel);
      chk("wrt_data", wrt_data, m_dat);
      chk("r0_drop", r0_drop, m_r0);
    end
  endtask

  initial begin
    vec_t r;
    bit   hold;

    // ALU-only stream
    tbl.push_back(mk(1, 1, 'h10, 0, 0, 0, 0,  0, 1, 0,  1, 1, 'h10, 0));
    tbl.push_back(mk(1, 2, 'h20, 0, 0, 0, 0,  0, 1, 0,  1, 2, 'h20, 0));
    tbl.push_back(mk(1, 3, 'h30, 0, 0, 0, 0,  0, 1, 0,  1, 3, 'h30, 0));
    tbl.push_back(mk(1, 4, 'h40, 0, 0, 0, 0,  0, 1, 0,  1, 4, 'h40, 0));
    tbl.push_back(mk(1, 5, 'h50, 0, 0, 0, 0,  0, 1, 0,  1, 5, 'h50, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 0,  0, 1, 0,  0, 0, 0,    0));
    // load buffering while the ALU keeps writing R7, then full-buffer stall
    tbl.push_back(mk(1, 7, 'h71, 1, 1, 'h101, 0,  0, 1, 0,  1, 7, 'h71,  0));
    tbl.push_back(mk(1, 7, 'h72, 1, 2, 'h102, 0,  0, 1, 1,  1, 7, 'h72,  0));
    tbl.push_back(mk(1, 7, 'h73, 1, 3, 'h103, 0,  0, 1, 2,  1, 7, 'h73,  0));
    tbl.push_back(mk(1, 7, 'h74, 1, 4, 'h104, 0,  0, 1, 3,  1, 7, 'h74,  0));
    tbl.push_back(mk(1, 7, 'h75, 0, 0, 0,     0,  1, 0, 4,  1, 1, 'h101, 0));
    tbl.push_back(mk(1, 7, 'h75, 0, 0, 0,     0,  0, 1, 3,  1, 7, 'h75,  0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 3,  1, 2, 'h102, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 2,  1, 3, 'h103, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 1,  1, 4, 'h104, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 0,  0, 0, 0,     0));
    // WAW conflict, then same-cycle push is not compared
    tbl.push_back(mk(0, 0, 0,       1, 3, 'hAAAA, 0,  0, 1, 0,  0, 0, 0,       0));
    tbl.push_back(mk(1, 3, 'hBBBB,  0, 0, 0,      0,  1, 1, 1,  1, 3, 'hAAAA,  0));
    tbl.push_back(mk(1, 3, 'hBBBB,  0, 0, 0,      0,  0, 1, 0,  1, 3, 'hBBBB,  0));
    tbl.push_back(mk(1, 5, 'h55,    1, 5, 'h5555, 0,  0, 1, 0,  1, 5, 'h55,    0));
    tbl.push_back(mk(0, 0, 0,       0, 0, 0,      0,  0, 1, 1,  1, 5, 'h5555,  0));
    // R0 filtering and sticky flag
    tbl.push_back(mk(1, 0, 'h5, 1, 0, 'h9, 0,  0, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   0,  0, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1,  0, 1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 'h5, 0, 0, 0,   1,  0, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1,  0, 1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 6, 'h66, 0, 0, 1, 0,  0, 0, 0,    0));
    tbl.push_back(mk(1, 0, 'h1, 0, 0, 0,   0,  0, 1, 1,  1, 6, 'h66, 1));
    tbl.push_back(mk(0, 0, 0,   0, 0, 0,   1,  0, 1, 0,  0, 0, 0,    0));
    // pointers now at DEPTH-1: fill to 2, push+pop across the wrap
    tbl.push_back(mk(1, 9, 'h91, 1, 1, 'h201, 0,  0, 1, 0,  1, 9, 'h91,  0));
    tbl.push_back(mk(1, 9, 'h92, 1, 2, 'h202, 0,  0, 1, 1,  1, 9, 'h92,  0));
    tbl.push_back(mk(0, 0, 0,    1, 3, 'h203, 0,  0, 1, 2,  1, 1, 'h201, 0));
    tbl.push_back(mk(0, 0, 0,    1, 4, 'h204, 0,  0, 1, 2,  1, 2, 'h202, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 2,  1, 3, 'h203, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 1,  1, 4, 'h204, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,     0,  0, 1, 0,  0, 0, 0,     0));

    // reset state, both while asserted and just after release
    #12;
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_rdy", mem_rdy, 1);
    chk("rst_stall", alu_stall, 0);
    chk("rst_en", wrt_en, 0);
    chk("rst_sel", wrt_sel, 0);
    chk("rst_data", wrt_data, 0);
    chk("rst_r0", r0_drop, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_en", wrt_en, 0);
    chk("post_rst_cnt", fifo_cnt, 0);

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // reset with three loads buffered
    apply(mk(1, 10, 'hA1, 1, 11, 'hB1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    apply(mk(1, 10, 'hA2, 1, 12, 'hB2, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    apply(mk(1, 10, 'hA3, 1, 13, 'hB3, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    alu_vld = 1'b1; alu_dst = 4'd11; alu_data = 'hCC;
    mem_vld = 1'b0; clr_r0_drop = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cnt", fifo_cnt, 0);
    chk("midrst_en", wrt_en, 0);
    chk("midrst_rdy", mem_rdy, 1);
    chk("midrst_stall", alu_stall, 0);
    mq.delete();
    m_sel = '0; m_dat = '0; m_r0 = 1'b0; m_stl = 1'b0;
    alu_vld = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // randomized traffic; a stalled ALU result is held by upstream
    hold = 1'b0;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 500; k++) begin
      if (!hold) begin
        r.av   = ($urandom_range(0, 3) != 0);
        r.ad   = 4'($urandom_range(0, 5));
        r.adat = $urandom;
      end
      r.mv   = ($urandom_range(0, 1) == 1);
      r.md   = 4'($urandom_range(0, 5));
      r.mdat = $urandom;
      r.clr  = ($urandom_range(0, 7) == 0);
      apply(r, 1'b0);
      hold = m_stl;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_wb_arb.md
# cpu_wb_arb

Writeback arbiter feeding the single write port (`wrt_en`/`wrt_sel`/`wrt_data`) of the CPU register file. Merges in-order ALU results with out-of-order-latency memory load returns. Load returns are buffered in a small FIFO. Writes to R0 are filtered so the register file never sees them. Preserves write-after-write order per destination register by stalling the ALU when its destination is still pending in the load buffer.

## Interface
Parameters:
- `DEPTH`, 4: load-return buffer entries; power of two, ≥2.
- `DW`, 32: data width.
- `AW`, 4: register index width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_vld`  in  1  ALU result valid this cycle.
- `alu_dst`  in  AW  ALU destination register.
- `alu_data`  in  DW  ALU result.
- `alu_stall`  out  1  ALU result not accepted this cycle; upstream holds `alu_*` stable (combinational).
- `mem_vld`  in  1  load return valid.
- `mem_dst`  in  AW  load destination register.
- `mem_data`  in  DW  load data.
- `mem_rdy`  out  1  buffer can accept; equals `count < DEPTH` (combinational from registered count).
- `wrt_en`  out  1  register-file write enable (registered).
- `wrt_sel`  out  AW  register-file write index (registered).
- `wrt_data`  out  DW  register-file write data (registered).
- `r0_drop`  out  1  sticky: a write to R0 was discarded.
- `clr_r0_drop`  in  1  synchronous clear of `r0_drop`.
- `fifo_cnt`  out  $clog2(DEPTH)+1  current buffer occupancy.

## Operation
- **Mem push.** Push occurs when `mem_vld && mem_rdy`.
  - `mem_dst==0`: accepted but not pushed, and `r0_drop` is set.
  - Otherwise `{mem_dst, mem_data}` is pushed at the tail.
  - No push while full, even if a pop occurs in the same cycle.
- **Conflict.** `conflict = alu_vld && alu_dst!=0 && (alu_dst matches dst of any valid buffer entry)`.
  - The match uses registered buffer contents only; an entry pushed this cycle is not compared.
- **Slot selection**, in priority order:
  1. `alu_vld && alu_dst==0`: ALU consumed, no ALU write, `r0_drop` set. The head pops if the buffer is non-empty.
  2. `alu_vld && !conflict && count<DEPTH`: ALU writes, `alu_stall=0`, no pop.
  3. `alu_vld && (conflict || count==DEPTH)`: head pops and writes, `alu_stall=1`.
  4. `!alu_vld && count>0`: head pops and writes.
  5. Otherwise: no write.
- **`alu_stall`** is 1 only in case 3. It is 0 whenever the buffer is empty.
- **Simultaneous push and pop:** `count` is unchanged. Pointers wrap modulo DEPTH.
- **`r0_drop`:** set has priority over `clr_r0_drop` in the same cycle.

## Timing
- Selected write is registered: source accepted in cycle N gives `wrt_*` valid in cycle N+1. The register file commits at the end of N+1.
- When no write occurs, `wrt_en=0` and `wrt_sel`/`wrt_data` hold their previous values.
- A pushed load is eligible to pop at the earliest in the cycle after the push (no fall-through).
- Reset values:
  - `wrt_en`, `wrt_sel`, `wrt_data`, `r0_drop`: 0.
  - Buffer: empty, pointers 0, `fifo_cnt` 0.
  - Combinational outputs under reset: `mem_rdy=1`, `alu_stall=0`.
- Reset asserted mid-operation discards all buffered loads immediately, with no writes issued.
- A conflicting ALU result stalls until every matching entry has drained. It is written in the cycle after the last matching pop, at the earliest.

## Structure
- Shared package `cpu_wb_pkg`:
  - `wb_req_t` struct `{logic [AW-1:0] dst; logic [DW-1:0] data;}`.
  - `REG_ZERO = 4'h0`.
  - Default `DEPTH`.
- Sub-module `cpu_wb_fifo`: synchronous FIFO of `wb_req_t`.
  - Outputs head, count and full.
  - Also outputs a per-query `dst_hit` flag: OR of `valid[i] && dst[i]==query`.
- Top level holds the selection logic, the output register and `r0_drop`.

## Test plan
- **ALU-only stream.** `alu_vld=1` with dst 1..5, data 0x10..0x50 → `wrt_en=1` one cycle later with matching sel/data; `alu_stall=0` throughout.
- **Load buffering.** With ALU busy (dst 7), push 4 loads dst 1..4 → `mem_rdy=0`, `fifo_cnt=4`. Next ALU cycle gets `alu_stall=1` and load dst 1 is written. ALU dst 7 is written once `count<4`.
- **Conflict ordering.** Push load dst 3 = 0xAAAA, then ALU dst 3 = 0xBBBB → `alu_stall=1`, write R3=0xAAAA, then R3=0xBBBB on the following cycle.
- **R0 filtering.** ALU dst 0 data 0x5 and load dst 0 data 0x9 → no `wrt_en`, `r0_drop=1`. `clr_r0_drop` returns it to 0; set and clear in the same cycle keeps it 1.
- **Push/pop same cycle at count 2 with wrap** (pointer at DEPTH-1) → `fifo_cnt` stays 2; FIFO order is preserved across the wrap.
- **Reset with 3 entries buffered** → `fifo_cnt=0`, `wrt_en=0`, no pending write after release.
